bolme_denetleyici: RTL and testbench

BOLME_DENETLEYICI -- requirements
Module: bolme_denetleyici

---
 rtl/bolme_denetleyici_pkg.sv | 28 ++
 rtl/bolme_denetleyici_adimi.sv | 30 +++
 rtl/bolme_denetleyici.sv | 129 ++++++++++++
 tb/tb_bolme_denetleyici.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bolme_denetleyici_pkg.sv
// Shared types and defaults for the iterative divide/remainder unit.
package bolme_denetleyici_pkg;

    localparam int VARSAYILAN_GENISLIK = 32;
    localparam int VARSAYILAN_ADIM     = 32;

    typedef enum logic [1:0] {
        ISLEM_DIV  = 2'b00,
        ISLEM_DIVU = 2'b01,
        ISLEM_REM  = 2'b10,
        ISLEM_REMU = 2'b11
    } islem_e;

    typedef enum logic [1:0] {
        BOSTA   = 2'b00,
        HESAPLA = 2'b01,
        BITTI   = 2'b10
    } durum_e;

    function automatic logic isaretli_mi(input islem_e islem);
        return (islem == ISLEM_DIV) || (islem == ISLEM_REM);
    endfunction

    function automatic logic kalan_mi(input islem_e islem);
        return (islem == ISLEM_REM) || (islem == ISLEM_REMU);
    endfunction

endpackage

// File: rtl/bolme_denetleyici_adimi.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module bolme_adimi #(
    parameter int VERI_GENISLIGI = 32
) (
    input  logic [VERI_GENISLIGI-1:0] kalan,
    input  logic [VERI_GENISLIGI-1:0] bolum,
    input  logic [VERI_GENISLIGI-1:0] bolen,
    output logic [VERI_GENISLIGI-1:0] yeni_kalan,
    output logic [VERI_GENISLIGI-1:0] yeni_bolum
);

    logic [VERI_GENISLIGI:0]   kaydir_s;
    logic [VERI_GENISLIGI-1:0] fark_s;
    logic                      sigar_s;

    // Compare in W+1 bits; the difference always fits in W bits because remainder < divisor.
    always_comb begin
        kaydir_s   = {kalan, bolum[VERI_GENISLIGI-1]};
        fark_s     = kaydir_s[VERI_GENISLIGI-1:0] - bolen;
        sigar_s    = (kaydir_s >= {1'b0, bolen});
        yeni_bolum = {bolum[VERI_GENISLIGI-2:0], sigar_s};
        if (sigar_s) begin
            yeni_kalan = fark_s;
        end else begin
            yeni_kalan = kaydir_s[VERI_GENISLIGI-1:0];
        end
    end

endmodule

// File: rtl/bolme_denetleyici.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: special-case detection, magnitude
// iteration through bolme_adimi, and sign correction of the final result.
module bolme_denetleyici
    import bolme_denetleyici_pkg::*;
#(
    parameter int VERI_GENISLIGI = VARSAYILAN_GENISLIK,
    parameter int ADIM_SAYISI    = VARSAYILAN_ADIM
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      basla_i,
    input  logic [1:0]                islem_i,
    input  logic [VERI_GENISLIGI-1:0] bolunen_i,
    input  logic [VERI_GENISLIGI-1:0] bolen_i,
    input  logic                      iptal_i,
    output logic                      durdur_o,
    output logic                      mesgul_o,
    output logic [VERI_GENISLIGI-1:0] sonuc_o,
    output logic                      sonuc_gecerli_o
);

    localparam int SAYAC_W = $clog2(ADIM_SAYISI);
    localparam logic [SAYAC_W-1:0] SON_ADIM = SAYAC_W'(ADIM_SAYISI - 1);
    localparam logic [VERI_GENISLIGI-1:0] EN_KUCUK = {1'b1, {(VERI_GENISLIGI-1){1'b0}}};

    durum_e                    durum_r;
    islem_e                    islem_r;
    logic [SAYAC_W-1:0]        sayac_r;
    logic [VERI_GENISLIGI-1:0] kalan_r, bolum_r, bolen_r, sonuc_r;
    logic                      bolunen_neg_r, bolen_neg_r, gecerli_r;

    islem_e                    yeni_islem_s;
    logic                      a_neg_s, b_neg_s, tasma_s;
    logic [VERI_GENISLIGI-1:0] a_mutlak_s, b_mutlak_s;
    logic [VERI_GENISLIGI-1:0] yeni_kalan_s, yeni_bolum_s, sonuc_sec_s;

    bolme_adimi #(.VERI_GENISLIGI(VERI_GENISLIGI)) u_adim (
        .kalan      (kalan_r),
        .bolum      (bolum_r),
        .bolen      (bolen_r),
        .yeni_kalan (yeni_kalan_s),
        .yeni_bolum (yeni_bolum_s)
    );

    // Decode the incoming request into sign flags and operand magnitudes.
    always_comb begin
        yeni_islem_s = islem_e'(islem_i);
        a_neg_s      = isaretli_mi(yeni_islem_s) & bolunen_i[VERI_GENISLIGI-1];
        b_neg_s      = isaretli_mi(yeni_islem_s) & bolen_i[VERI_GENISLIGI-1];
        a_mutlak_s   = a_neg_s ? -bolunen_i : bolunen_i;
        b_mutlak_s   = b_neg_s ? -bolen_i : bolen_i;
        tasma_s      = isaretli_mi(yeni_islem_s) && (bolunen_i == EN_KUCUK) && (bolen_i == '1);
    end

    // Sign-corrected result taken from the last iteration step.
    always_comb begin
        sonuc_sec_s = '0;
        if (kalan_mi(islem_r)) begin
            sonuc_sec_s = bolunen_neg_r ? -yeni_kalan_s : yeni_kalan_s;
        end else begin
            sonuc_sec_s = (bolunen_neg_r ^ bolen_neg_r) ? -yeni_bolum_s : yeni_bolum_s;
        end
    end

    // Sequencer, datapath registers and registered result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_r       <= BOSTA;
            islem_r       <= ISLEM_DIV;
            sayac_r       <= '0;
            kalan_r       <= '0;
            bolum_r       <= '0;
            bolen_r       <= '0;
            sonuc_r       <= '0;
            bolunen_neg_r <= 1'b0;
            bolen_neg_r   <= 1'b0;
            gecerli_r     <= 1'b0;
        end else begin
            gecerli_r <= 1'b0;
            case (durum_r)
                BOSTA: begin
                    if (basla_i && !iptal_i) begin
                        islem_r       <= yeni_islem_s;
                        bolunen_neg_r <= a_neg_s;
                        bolen_neg_r   <= b_neg_s;
                        if (bolen_i == '0) begin
                            durum_r   <= BITTI;
                            gecerli_r <= 1'b1;
                            sonuc_r   <= kalan_mi(yeni_islem_s) ? bolunen_i : '1;
                        end else if (tasma_s) begin
                            durum_r   <= BITTI;
                            gecerli_r <= 1'b1;
                            sonuc_r   <= kalan_mi(yeni_islem_s) ? '0 : EN_KUCUK;
                        end else begin
                            durum_r <= HESAPLA;
                            sayac_r <= '0;
                            kalan_r <= '0;
                            bolum_r <= a_mutlak_s;
                            bolen_r <= b_mutlak_s;
                        end
                    end
                end
                HESAPLA: begin
                    if (iptal_i) begin
                        durum_r <= BOSTA;
                    end else begin
                        kalan_r <= yeni_kalan_s;
                        bolum_r <= yeni_bolum_s;
                        if (sayac_r == SON_ADIM) begin
                            durum_r   <= BITTI;
                            gecerli_r <= 1'b1;
                            sonuc_r   <= sonuc_sec_s;
                        end else begin
                            sayac_r <= sayac_r + SAYAC_W'(1);
                        end
                    end
                end
                BITTI:   durum_r <= BOSTA;
                default: durum_r <= BOSTA;
            endcase
        end
    end

    assign durdur_o        = ((durum_r == BOSTA) && basla_i && !iptal_i) || (durum_r == HESAPLA);
    assign mesgul_o        = (durum_r != BOSTA);
    assign sonuc_o         = sonuc_r;
    assign sonuc_gecerli_o = gecerli_r;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Directed-vector bench: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever sonuc_gecerli_o is seen.
module tb_bolme_denetleyici;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        basla_i = 1'b0;
    logic [1:0]  islem_i = 2'b00;
    logic [31:0] bolunen_i = 32'd0;
    logic [31:0] bolen_i = 32'd0;
    logic        iptal_i = 1'b0;
    logic        durdur_o, mesgul_o, sonuc_gecerli_o;
    logic [31:0] sonuc_o;

    typedef struct {
        logic [31:0] deger;
        int          cevrim;
    } beklenti_t;

    beklenti_t sb_q[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    bolme_denetleyici #(.VERI_GENISLIGI(32), .ADIM_SAYISI(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .basla_i         (basla_i),
        .islem_i         (islem_i),
        .bolunen_i       (bolunen_i),
        .bolen_i         (bolen_i),
        .iptal_i         (iptal_i),
        .durdur_o        (durdur_o),
        .mesgul_o        (mesgul_o),
        .sonuc_o         (sonuc_o),
        .sonuc_gecerli_o (sonuc_gecerli_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", ad, cyc, gercek, beklenen);
        end
    endtask

    // Monitor: every valid strobe must match the oldest pending expectation.
    always @(negedge clk_i) begin
        if (sonuc_gecerli_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid cyc=%0d got=%h expected=no strobe", cyc, sonuc_o);
            end else begin
                beklenti_t b;
                b = sb_q.pop_front();
                kontrol("sonuc", sonuc_o, b.deger);
                kontrol("valid_cycle", 32'(cyc), 32'(b.cevrim));
            end
        end
    end

    task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] beklenen, input bit kisa, input bit arada_basla);
        int n;
        @(negedge clk_i);
        islem_i = op; bolunen_i = a; bolen_i = b; basla_i = 1'b1;
        n = cyc;
        sb_q.push_back('{beklenen, n + (kisa ? 1 : 33)});
        #1;
        kontrol("durdur_start", {31'd0, durdur_o}, 32'd1);
        if (kisa) begin
            @(negedge clk_i);
            basla_i = 1'b0;
            #1;
            kontrol("durdur_bitti", {31'd0, durdur_o}, 32'd0);
            kontrol("mesgul_bitti", {31'd0, mesgul_o}, 32'd1);
        end else begin
            for (int k = 1; k <= 33; k++) begin
                @(negedge clk_i);
                basla_i = arada_basla && (k == 3);
                if (basla_i) begin
                    islem_i = 2'b11; bolunen_i = 32'd50; bolen_i = 32'd3;
                end
                #1;
                kontrol("durdur_iter", {31'd0, durdur_o}, (k <= 32) ? 32'd1 : 32'd0);
            end
            basla_i = 1'b0;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        kontrol("reset_sonuc", sonuc_o, 32'd0);
        kontrol("reset_valid", {31'd0, sonuc_gecerli_o}, 32'd0);
        kontrol("reset_mesgul", {31'd0, mesgul_o}, 32'd0);
        kontrol("reset_durdur", {31'd0, durdur_o}, 32'd0);
        rst_i = 1'b1;

        islem_yap(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        islem_yap(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        islem_yap(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        islem_yap(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        islem_yap(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0);
        islem_yap(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
        islem_yap(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        islem_yap(2'b10, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0);
        islem_yap(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        islem_yap(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        islem_yap(2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 1'b0);
        islem_yap(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 1'b0);

        // Abort mid-iteration: no strobe, previous result (0xF) held.
        @(negedge clk_i);
        islem_i = 2'b01; bolunen_i = 32'd1000; bolen_i = 32'd3; basla_i = 1'b1;
        n = cyc;
        @(negedge clk_i);
        basla_i = 1'b0;
        while (cyc < n + 10) @(negedge clk_i);
        iptal_i = 1'b1;
        @(negedge clk_i);
        iptal_i = 1'b0;
        #1;
        kontrol("iptal_durdur", {31'd0, durdur_o}, 32'd0);
        kontrol("iptal_mesgul", {31'd0, mesgul_o}, 32'd0);
        kontrol("iptal_sonuc", sonuc_o, 32'hF);
        islem_yap(2'b01, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);

        // Reset mid-iteration clears outputs and suppresses the strobe.
        @(negedge clk_i);
        islem_i = 2'b01; bolunen_i = 32'd1000; bolen_i = 32'd7; basla_i = 1'b1;
        n = cyc;
        @(negedge clk_i);
        basla_i = 1'b0;
        while (cyc < n + 5) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        kontrol("rst_sonuc", sonuc_o, 32'd0);
        kontrol("rst_valid", {31'd0, sonuc_gecerli_o}, 32'd0);
        kontrol("rst_durdur", {31'd0, durdur_o}, 32'd0);
        kontrol("rst_mesgul", {31'd0, mesgul_o}, 32'd0);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);

        islem_yap(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        repeat (5) @(negedge clk_i);
        kontrol("pending_results", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
